// File: rtl/nybble_pkg.sv
// Shared opcode numbering, fetch FSM encoding and operand-size lookup for
// the nybbleForth front end.
package nybble_pkg;

  localparam logic [3:0] OP_NOOP    = 4'd0;
  localparam logic [3:0] OP_CALL    = 4'd1;
  localparam logic [3:0] OP_EXIT    = 4'd2;
  localparam logic [3:0] OP_0BRANCH = 4'd3;
  localparam logic [3:0] OP_STORE   = 4'd4;
  localparam logic [3:0] OP_FETCH   = 4'd5;
  localparam logic [3:0] OP_LIT     = 4'd6;
  localparam logic [3:0] OP_ADD     = 4'd7;
  localparam logic [3:0] OP_NAND    = 4'd8;
  localparam logic [3:0] OP_TOR     = 4'd9;
  localparam logic [3:0] OP_RFROM   = 4'd10;

  typedef enum logic [2:0] {
    ST_IFETCH = 3'd0,
    ST_ICAP   = 3'd1,
    ST_DECODE = 3'd2,
    ST_ARD    = 3'd3,
    ST_ACAP   = 3'd4,
    ST_OUT    = 3'd5
  } fetch_state_t;

  // Number of inline operand bytes that follow the opcode's byte.
  function automatic logic [1:0] arg_bytes(input logic [3:0] opcode);
    case (opcode)
      OP_CALL, OP_LIT: arg_bytes = 2'd2;
      OP_0BRANCH:      arg_bytes = 2'd1;
      default:         arg_bytes = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/nybble_fetch.sv
// Instruction fetch for the nybbleForth core: splits each memory byte into two
// opcodes, gathers inline operands and presents one instruction at a time.
module nybble_fetch
  import nybble_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          MEM_AW   = 12
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [3:0]        op_code,
  output logic [15:0]       op_arg,
  output logic [15:0]       op_pc,
  output logic [15:0]       op_next_pc,
  input  logic              redirect,
  input  logic [15:0]       redirect_pc
);

  fetch_state_t        state, state_n;
  logic [15:0]         pc, pc_n;
  logic [15:0]         ibuf_pc;
  logic [7:0]          ibuf;
  logic [7:0]          arg_lo;
  logic [1:0]          argcnt;
  logic                nib_sel;
  logic [3:0]          opc;
  logic                accept;
  logic                last_arg;
  logic signed [15:0]  boff;

  assign opc      = nib_sel ? ibuf[3:0] : ibuf[7:4];
  assign accept   = op_valid & op_ready;
  assign last_arg = (argcnt == 2'd1);
  assign boff     = {{8{mem_rdata[7]}}, mem_rdata};

  always_comb begin
    state_n = state;
    pc_n    = pc;
    case (state)
      // The first IFETCH after reset only arms the registered read strobe.
      ST_IFETCH: if (mem_rd) begin
        state_n = ST_ICAP;
        pc_n    = pc + 16'd1;
      end
      ST_ICAP:   state_n = ST_DECODE;
      ST_DECODE: state_n = (arg_bytes(opc) != 2'd0) ? ST_ARD : ST_OUT;
      ST_ARD: begin
        state_n = ST_ACAP;
        pc_n    = pc + 16'd1;
      end
      ST_ACAP:   state_n = last_arg ? ST_OUT : ST_ARD;
      ST_OUT:    if (accept) state_n = nib_sel ? ST_IFETCH : ST_DECODE;
      default:   state_n = ST_IFETCH;
    endcase
    if (redirect) begin
      state_n = ST_IFETCH;
      pc_n    = redirect_pc;
    end
  end

  // Control and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IFETCH;
      pc         <= RESET_PC;
      nib_sel    <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      op_valid   <= 1'b0;
      op_code    <= 4'd0;
      op_arg     <= 16'd0;
      op_pc      <= 16'd0;
      op_next_pc <= 16'd0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      mem_rd   <= (state_n == ST_IFETCH) || (state_n == ST_ARD);
      mem_addr <= pc_n[MEM_AW-1:0];
      op_valid <= (state_n == ST_OUT);

      if (redirect || state == ST_ICAP)
        nib_sel <= 1'b0;
      else if (state == ST_OUT && accept && !nib_sel)
        nib_sel <= 1'b1;

      if (state == ST_DECODE) begin
        op_code    <= opc;
        op_pc      <= ibuf_pc;
        op_arg     <= 16'd0;
        op_next_pc <= pc;
      end

      // pc already points past the final operand byte here.
      if (state == ST_ACAP && last_arg) begin
        op_next_pc <= pc;
        if (op_code == OP_0BRANCH)
          op_arg <= pc + $unsigned(boff);
        else
          op_arg <= {mem_rdata, arg_lo};
      end
    end
  end

  // Fetch datapath
  always_ff @(posedge clock) begin
    if (state == ST_IFETCH) ibuf_pc <= pc;
    if (state == ST_ICAP)   ibuf    <= mem_rdata;
    if (state == ST_DECODE) argcnt  <= arg_bytes(opc);
    if (state == ST_ACAP) begin
      argcnt <= argcnt - 2'd1;
      arg_lo <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_nybble_fetch.sv
// Bench for nybble_fetch: directed table of short programs, multi-cycle corner
// sequences, then random programs/handshakes against an instruction-level model.
module tb_nybble_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_code;
  logic [15:0] op_arg;
  logic [15:0] op_pc;
  logic [15:0] op_next_pc;
  logic        redirect;
  logic [15:0] redirect_pc;

  nybble_fetch #(.RESET_PC(16'h0000), .MEM_AW(12)) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_code     (op_code),
    .op_arg      (op_arg),
    .op_pc       (op_pc),
    .op_next_pc  (op_next_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [4096];

  always @(posedge clock) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= 8'($urandom);
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction-level reference: walk the byte stream directly.
  logic [15:0] m_pc, m_bpc;
  bit          m_sel;

  task automatic model_restart(input logic [15:0] pc);
    m_pc  = pc;
    m_sel = 1'b0;
  endtask

  task automatic model_next(output logic [51:0] e);
    logic [7:0]  b, off;
    logic [3:0]  c;
    logic [15:0] a, t;
    if (!m_sel) begin
      m_bpc = m_pc;
      m_pc  = m_pc + 16'd1;
    end
    b = mem[m_bpc[11:0]];
    c = m_sel ? b[3:0] : b[7:4];
    a = 16'd0;
    if (c == 4'd1 || c == 4'd6) begin
      t    = m_pc + 16'd1;
      a    = {mem[t[11:0]], mem[m_pc[11:0]]};
      m_pc = m_pc + 16'd2;
    end else if (c == 4'd3) begin
      off  = mem[m_pc[11:0]];
      m_pc = m_pc + 16'd1;
      a    = m_pc + {{8{off[7]}}, off};
    end
    m_sel = !m_sel;
    e = {c, a, m_bpc, m_pc};
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (op_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic get_op(output logic [51:0] f, output bit ok);
    op_ready = 1'b1;
    wait_valid(ok);
    f = {op_code, op_arg, op_pc, op_next_pc};
    @(posedge clock);
    #1 op_ready = 1'b0;
  endtask

  task automatic wait_rd(output logic [11:0] a, output bit ok);
    ok = 1'b0;
    a  = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (mem_rd) begin a = mem_addr; ok = 1'b1; break; end
    end
  endtask

  task automatic redirect_to(input logic [15:0] pc);
    @(negedge clock);
    redirect    = 1'b1;
    redirect_pc = pc;
    @(negedge clock);
    redirect    = 1'b0;
  endtask

  task automatic load(input logic [15:0] start, input logic [39:0] bytes, input int nb);
    logic [15:0] a;
    for (int i = 0; i < nb; i++) begin
      a = start + 16'(i);
      mem[a[11:0]] = bytes[i*8 +: 8];
    end
  endtask

  typedef struct {
    logic [15:0] start;
    logic [39:0] bytes;
    int          nb;
    logic [3:0]  hc;
    logic [15:0] ha, hn;
    logic [3:0]  lc;
    logic [15:0] la, ln;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [51:0] f, e, h;
    logic [11:0] a;
    bit          ok, v1, v2, stable;
    int          lat;

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    reset = 1'b1; op_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;

    tbl[0] = '{16'h0000, 40'h0000123467, 3, 4'h6, 16'h1234, 16'h0003, 4'h7, 16'h0000, 16'h0003};
    tbl[1] = '{16'h0010, 40'h000000FE30, 2, 4'h3, 16'h0010, 16'h0012, 4'h0, 16'h0000, 16'h0012};
    tbl[2] = '{16'hFFFE, 40'h000055AA60, 3, 4'h6, 16'h55AA, 16'h0001, 4'h0, 16'h0000, 16'h0001};
    tbl[3] = '{16'h0100, 40'h0012340536, 4, 4'h3, 16'h0107, 16'h0102, 4'h6, 16'h1234, 16'h0104};
    tbl[4] = '{16'h0200, 40'h0080ABCD13, 4, 4'h1, 16'hABCD, 16'h0203, 4'h3, 16'h0184, 16'h0204};
    tbl[5] = '{16'h0300, 40'h00000000F2, 1, 4'hF, 16'h0000, 16'h0301, 4'h2, 16'h0000, 16'h0301};
    tbl[6] = '{16'h0400, 40'h1234020011, 5, 4'h1, 16'h0200, 16'h0403, 4'h1, 16'h1234, 16'h0405};
    tbl[7] = '{16'h0001, 40'h000000F003, 2, 4'h0, 16'h0000, 16'h0002, 4'h3, 16'hFFF3, 16'h0003};

    repeat (2) @(negedge clock);
    check("reset_outputs", {op_valid, mem_rd, op_code, op_arg, op_pc, op_next_pc}, 64'd0);
    reset = 1'b0;
    wait_rd(a, ok);
    check("reset_first_rd", {ok, a}, {1'b1, 12'h000});

    for (int i = 0; i < 8; i++) begin
      load(tbl[i].start, tbl[i].bytes, tbl[i].nb);
      redirect_to(tbl[i].start);
      get_op(f, ok);
      check($sformatf("tbl%0d_hi", i), {ok, f},
            {1'b1, tbl[i].hc, tbl[i].ha, tbl[i].start, tbl[i].hn});
      get_op(f, ok);
      check($sformatf("tbl%0d_lo", i), {ok, f},
            {1'b1, tbl[i].lc, tbl[i].la, tbl[i].start, tbl[i].ln});
      wait_rd(a, ok);
      check($sformatf("tbl%0d_next_rd", i), {ok, a}, {1'b1, tbl[i].ln[11:0]});
    end

    // Redirect coinciding with an accept drops the pending low nibble.
    load(16'h0500, 40'h0000020010, 3);
    mem[12'h200] = 8'h5A;
    redirect_to(16'h0500);
    wait_valid(ok);
    f = {op_code, op_arg, op_pc, op_next_pc};
    op_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
    @(posedge clock);
    #1 op_ready = 1'b0; redirect = 1'b0;
    check("redir_accept_call", {ok, f}, {1'b1, 4'h1, 16'h0200, 16'h0500, 16'h0503});
    get_op(f, ok);
    check("redir_accept_next", {ok, f}, {1'b1, 4'h5, 16'h0000, 16'h0200, 16'h0201});

    // Backpressure, high-nibble latency and low-nibble latency.
    mem[12'h600] = 8'h70;
    redirect_to(16'h0600);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (op_valid) break;
      lat++;
    end
    check("hi_latency", 64'(lat), 64'd2);
    h = {op_code, op_arg, op_pc, op_next_pc};
    check("stall_op", h, {4'h7, 16'h0000, 16'h0600, 16'h0601});
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      stable = op_valid && !mem_rd && ({op_code, op_arg, op_pc, op_next_pc} == h);
      check($sformatf("stall_cyc%0d", i), {63'd0, stable}, 64'd1);
    end
    op_ready = 1'b1;
    @(posedge clock);
    #1 op_ready = 1'b0;
    @(negedge clock); v1 = op_valid;
    @(negedge clock); v2 = op_valid;
    check("lo_latency", {v1, v2}, 2'b01);
    check("stall_lo", {op_code, op_arg, op_pc, op_next_pc}, {4'h0, 16'h0000, 16'h0600, 16'h0601});

    // Reset while capturing a literal operand.
    load(16'h0700, 40'h0000221160, 3);
    mem[12'h000] = 8'h20;
    redirect_to(16'h0700);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (mem_rd && mem_addr == 12'h701) begin ok = 1'b1; break; end
    end
    check("acap_reached", {63'd0, ok}, 64'd1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_in_acap", {op_valid, mem_rd}, 2'b00);
    wait_rd(a, ok);
    check("reset_restart_rd", {ok, a}, {1'b1, 12'h000});
    get_op(f, ok);
    check("reset_restart_op", {ok, f}, {1'b1, 4'h2, 16'h0000, 16'h0000, 16'h0001});

    // Random programs, handshakes and redirects.
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clock);
      op_ready    = ($urandom_range(0, 3) != 0);
      redirect    = (cyc == 0) || ($urandom_range(0, 49) == 0);
      redirect_pc = 16'($urandom);
      if (op_valid && op_ready && cyc != 0) begin
        model_next(e);
        check("rand_op", {op_code, op_arg, op_pc, op_next_pc}, e);
      end
      if (redirect) model_restart(redirect_pc);
    end
    @(negedge clock);
    op_ready = 1'b0; redirect = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
